debug_mem_dumper: RTL and testbench

Debug-side reader for the data memory's debug port. On a start command it walks a range of word addresses, drives the memory's debug address, and captures each returned 32-bit word. It streams each word as bytes (little endian, LSB first) over a valid/ready byte interface toward the debug UART transmitter. It sits between the debug controller and the data memory and never touches the pipeline read/write port.

---
 rtl/debug_mem_dumper.sv | 232 +++++++++++++++++++++++
 tb/tb_debug_mem_dumper.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_mem_dumper.sv
// -----------------------------------------------------------------------------
// debug_mem_dumper
//
// Purpose:
//   Debug-side reader for the data memory's debug port. A start command walks
//   a range of word addresses on the memory debug port. Each returned 32-bit
//   word is captured and streamed out as four bytes, least significant byte
//   first, over a valid/ready byte interface toward the debug UART
//   transmitter. The pipeline read/write port of the memory is never touched.
//
// Optional feature (macro DEBUG_DUMP_CHECKSUM_EN):
//   When defined, one extra byte is sent after the last data byte, using the
//   same handshake. Its value is the XOR of every byte sent in this dump. A
//   zero-length dump sends only this byte, with value 0x00. When the macro is
//   undefined, DONE follows the last data byte directly.
//
// Ports:
//   clk           system clock, all logic on posedge
//   rst           asynchronous active-low reset
//   i_start       one-cycle start pulse, ignored while busy or while done pulses
//   i_base_addr   first byte address, sampled on an accepted start
//   i_num_words   number of words to dump, sampled on an accepted start
//   o_debug_addr  registered byte address to the memory debug port
//   i_debug_data  memory debug data, valid one clock after o_debug_addr changes
//   o_tx_data     byte to the transmitter
//   o_tx_valid    byte valid
//   i_tx_ready    transmitter accepts the byte
//   o_busy        high from an accepted start until the done cycle (exclusive)
//   o_done        one-cycle pulse when the dump completes
// -----------------------------------------------------------------------------
module debug_mem_dumper #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 64,
    parameter int ADDR_WIDTH = $clog2(MEM_SIZE),
    parameter int CNT_WIDTH  = ADDR_WIDTH - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [CNT_WIDTH-1:0]  i_num_words,
    output logic [ADDR_WIDTH-1:0] o_debug_addr,
    input  logic [DATA_WIDTH-1:0] i_debug_data,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_busy,
    output logic                  o_done
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SEND    = 3'd3,
`ifdef DEBUG_DUMP_CHECKSUM_EN
        ST_CHK     = 3'd4,
`endif
        ST_DONE    = 3'd5
    } state_t;

    state_t                 state_r;
    logic [DATA_WIDTH-1:0]  word_r;
    logic [1:0]             byte_idx_r;
    logic [CNT_WIDTH-1:0]   count_r;
    logic [ADDR_WIDTH-1:0]  debug_addr_r;
    logic [7:0]             tx_data_r;
    logic                   tx_valid_r;
    logic                   busy_r;
    logic                   done_r;
`ifdef DEBUG_DUMP_CHECKSUM_EN
    logic [7:0]             chk_r;
`endif

    logic                   accept_start_s;
    logic                   xfer_s;
    logic [7:0]             next_byte_s;

    // Pick one byte lane of the captured word, lane 0 being the LSB.
    function automatic logic [7:0] select_byte(input logic [DATA_WIDTH-1:0] word,
                                               input logic [1:0]            idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

`ifdef DEBUG_DUMP_CHECKSUM_EN
    // Fold one transferred byte into the running XOR checksum.
    function automatic logic [7:0] fold_checksum(input logic [7:0] acc,
                                                 input logic [7:0] b);
        return acc ^ b;
    endfunction
`endif

    // A start landing on the done-pulse cycle is dropped, so the guard on
    // done_r matters even though the FSM is already back in IDLE.
    assign accept_start_s = i_start && !done_r;
    assign xfer_s         = tx_valid_r && i_tx_ready;
    // Wraps from lane 3 back to lane 0; that value is only used mid-word.
    assign next_byte_s    = select_byte(word_r, byte_idx_r + 2'd1);

    // Dump sequencer: walks the word range and drives all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            word_r       <= {DATA_WIDTH{1'b0}};
            byte_idx_r   <= 2'd0;
            count_r      <= {CNT_WIDTH{1'b0}};
            debug_addr_r <= {ADDR_WIDTH{1'b0}};
            tx_data_r    <= 8'h00;
            tx_valid_r   <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
            chk_r        <= 8'h00;
`endif
        end else begin
            // done is a single-cycle pulse; only ST_DONE raises it.
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_start_s) begin
                        busy_r  <= 1'b1;
                        count_r <= i_num_words;
`ifdef DEBUG_DUMP_CHECKSUM_EN
                        chk_r   <= 8'h00;
`endif
                        if (i_num_words == {CNT_WIDTH{1'b0}}) begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
                            // Empty dump still emits its (zero) checksum.
                            tx_data_r  <= 8'h00;
                            tx_valid_r <= 1'b1;
                            state_r    <= ST_CHK;
`else
                            state_r    <= ST_DONE;
`endif
                        end else begin
                            debug_addr_r <= i_base_addr;
                            state_r      <= ST_WAIT;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                // Memory registers the debug read; data is usable next cycle.
                ST_WAIT: begin
                    state_r <= ST_CAPTURE;
                end

                ST_CAPTURE: begin
                    word_r     <= i_debug_data;
                    byte_idx_r <= 2'd0;
                    tx_data_r  <= i_debug_data[7:0];
                    tx_valid_r <= 1'b1;
                    state_r    <= ST_SEND;
                end

                ST_SEND: begin
                    if (xfer_s) begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
                        chk_r <= fold_checksum(chk_r, tx_data_r);
`endif
                        if (byte_idx_r != 2'd3) begin
                            byte_idx_r <= byte_idx_r + 2'd1;
                            tx_data_r  <= next_byte_s;
                        end else begin
                            byte_idx_r <= 2'd0;
                            count_r    <= count_r - CNT_WIDTH'(1);
                            if (count_r != CNT_WIDTH'(1)) begin
                                // Natural width wrap gives the modulo address step.
                                tx_valid_r   <= 1'b0;
                                debug_addr_r <= debug_addr_r + ADDR_WIDTH'(4);
                                state_r      <= ST_WAIT;
                            end else begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
                                // Include the byte leaving on this edge.
                                tx_data_r  <= fold_checksum(chk_r, tx_data_r);
                                tx_valid_r <= 1'b1;
                                state_r    <= ST_CHK;
`else
                                tx_valid_r <= 1'b0;
                                state_r    <= ST_DONE;
`endif
                            end
                        end
                    end else begin
                        // Back-pressure: data and valid hold stable.
                        state_r <= ST_SEND;
                    end
                end

`ifdef DEBUG_DUMP_CHECKSUM_EN
                ST_CHK: begin
                    if (xfer_s) begin
                        tx_valid_r <= 1'b0;
                        state_r    <= ST_DONE;
                    end else begin
                        state_r <= ST_CHK;
                    end
                end
`endif

                ST_DONE: begin
                    done_r     <= 1'b1;
                    busy_r     <= 1'b0;
                    tx_valid_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end

                default: begin
                    tx_valid_r <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_debug_addr = debug_addr_r;
    assign o_tx_data    = tx_data_r;
    assign o_tx_valid   = tx_valid_r;
    assign o_busy       = busy_r;
    assign o_done       = done_r;

endmodule

// File: tb/tb_debug_mem_dumper.sv
// -----------------------------------------------------------------------------
// tb_debug_mem_dumper
//
// Directed bench for debug_mem_dumper. A byte-array model of the data memory
// answers the debug port with a one-clock registered read. Each dump pushes
// its expected byte stream onto a scoreboard queue. A negedge monitor pops and
// compares every handshaken byte, and it checks that data holds under
// back-pressure. Control timing is checked inline one clock after each edge.
// -----------------------------------------------------------------------------
module tb_debug_mem_dumper;

    localparam int AW = 6;
    localparam int CW = 5;
`ifdef DEBUG_DUMP_CHECKSUM_EN
    localparam int CHK_EXTRA = 1;
`else
    localparam int CHK_EXTRA = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base = '0;
    logic [CW-1:0] num = '0;
    logic [AW-1:0] dbg_addr;
    logic [31:0]   dbg_data = 32'h0;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic          busy;
    logic          done;

    logic [7:0]    mem [0:63];
    logic [7:0]    exp_q [$];
    int            total = 0;
    int            bad = 0;
    int            cyc_n = 0;

    debug_mem_dumper dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (start),
        .i_base_addr  (base),
        .i_num_words  (num),
        .o_debug_addr (dbg_addr),
        .i_debug_data (dbg_data),
        .o_tx_data    (tx_data),
        .o_tx_valid   (tx_valid),
        .i_tx_ready   (tx_ready),
        .o_busy       (busy),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    // Memory debug port model: registered read, byte addresses wrap mod 64.
    always @(posedge clk) begin
        dbg_data <= {mem[dbg_addr + 6'd3], mem[dbg_addr + 6'd2],
                     mem[dbg_addr + 6'd1], mem[dbg_addr]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    // Build the expected byte stream of a dump from the memory model.
    task automatic expect_dump(input logic [AW-1:0] b, input int n);
        logic [7:0]    acc;
        logic [AW-1:0] a;
        acc = 8'h00;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 4; j++) begin
                a = b + AW'(4 * k + j);
                exp_q.push_back(mem[a]);
                acc = acc ^ mem[a];
            end
        end
`ifdef DEBUG_DUMP_CHECKSUM_EN
        exp_q.push_back(acc);
`endif
    endtask

    task automatic pulse_start(input logic [AW-1:0] b, input logic [CW-1:0] n);
        base  = b;
        num   = n;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    // Wait (bounded) for o_done, then check latency, the pulse and the scoreboard.
    task automatic wait_done(input string tag, input int s, input int exp_lat);
        int got;
        got = -1;
        for (int i = 0; i < 300; i++) begin
            if (done === 1'b1) begin
                got = cyc_n - s;
                break;
            end
            cyc();
        end
        chk({tag, "_done_latency"}, got, exp_lat);
        if (got >= 0) begin
            chk({tag, "_busy_at_done"}, busy, 1'b0);
            chk({tag, "_valid_at_done"}, tx_valid, 1'b0);
            cyc();
            chk({tag, "_done_one_cycle"}, done, 1'b0);
        end
        chk({tag, "_sb_drained"}, exp_q.size(), 0);
    endtask

    // Scoreboard monitor, sampling on the inactive edge.
    initial begin
        logic       pv;
        logic       pr;
        logic [7:0] pd;
        pv = 1'b0;
        pr = 1'b0;
        pd = 8'h00;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                pv = 1'b0;
                pr = 1'b0;
            end else begin
                if (pv && !pr) begin
                    chk("hold_valid", tx_valid, 1'b1);
                    chk("hold_data", tx_data, pd);
                end
                if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $error("FAIL extra_byte observed=%0h expected=none", tx_data);
                    end else begin
                        chk("tx_byte", tx_data, exp_q.pop_front());
                    end
                end
                pv = tx_valid;
                pr = tx_ready;
                pd = tx_data;
            end
        end
    end

    initial begin
        int s;
        for (int i = 0; i < 64; i++) mem[i] = 8'(i * 13 + 5);
        mem[8]  = 8'h44; mem[9]  = 8'h33; mem[10] = 8'h22; mem[11] = 8'h11;
        mem[60] = 8'hDD; mem[61] = 8'hCC; mem[62] = 8'hBB; mem[63] = 8'hAA;
        mem[0]  = 8'h04; mem[1]  = 8'h03; mem[2]  = 8'h02; mem[3]  = 8'h01;

        // Reset state.
        cyc(); cyc();
        chk("rst_addr", dbg_addr, 6'd0);
        chk("rst_data", tx_data, 8'h00);
        chk("rst_valid", tx_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        rst = 1'b1;
        cyc();

        // Single word, ready held high.
        tx_ready = 1'b1;
        expect_dump(6'd8, 1);
        s = cyc_n;
        pulse_start(6'd8, 5'd1);
        chk("t1_busy", busy, 1'b1);
        chk("t1_addr", dbg_addr, 6'd8);
        chk("t1_valid_c1", tx_valid, 1'b0);
        cyc();
        chk("t1_valid_c2", tx_valid, 1'b0);
        cyc();
        chk("t1_first_valid", tx_valid, 1'b1);
        chk("t1_byte0", tx_data, 8'h44);
        wait_done("t1", s, 8 + CHK_EXTRA);

        // Back-pressure: ready low for 5 clocks after the first valid.
        tx_ready = 1'b0;
        expect_dump(6'd8, 1);
        s = cyc_n;
        pulse_start(6'd8, 5'd1);
        cyc(); cyc();
        chk("t2_first_valid", tx_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t2_stall_valid", tx_valid, 1'b1);
            chk("t2_stall_data", tx_data, 8'h44);
        end
        tx_ready = 1'b1;
        wait_done("t2", s, 13 + CHK_EXTRA);

        // Address wrap from 60 to 0.
        expect_dump(6'd60, 2);
        s = cyc_n;
        pulse_start(6'd60, 5'd2);
        chk("t3_addr_first", dbg_addr, 6'd60);
        for (int i = 0; i < 5; i++) cyc();
        chk("t3_addr_hold", dbg_addr, 6'd60);
        cyc();
        chk("t3_addr_wrap", dbg_addr, 6'd0);
        wait_done("t3", s, 14 + CHK_EXTRA);

        // Zero count.
        expect_dump(6'd12, 0);
        s = cyc_n;
        pulse_start(6'd12, 5'd0);
        chk("t4_busy", busy, 1'b1);
        wait_done("t4", s, 2 + CHK_EXTRA);

        // Unaligned base is passed through unmodified.
        expect_dump(6'd2, 2);
        s = cyc_n;
        pulse_start(6'd2, 5'd2);
        chk("t5_addr", dbg_addr, 6'd2);
        wait_done("t5", s, 14 + CHK_EXTRA);

        // A second start during word 1 is ignored.
        expect_dump(6'd16, 2);
        s = cyc_n;
        pulse_start(6'd16, 5'd2);
        cyc(); cyc(); cyc();
        pulse_start(6'd40, 5'd3);
        chk("t6_busy_kept", busy, 1'b1);
        chk("t6_addr_kept", dbg_addr, 6'd16);
        wait_done("t6", s, 14 + CHK_EXTRA);

        // Start on the done-pulse cycle is dropped, the next cycle is taken.
        expect_dump(6'd24, 1);
        s = cyc_n;
        pulse_start(6'd24, 5'd1);
        for (int i = 0; i < 100; i++) begin
            if (done === 1'b1) break;
            cyc();
        end
        chk("t7_done_latency", cyc_n - s, 8 + CHK_EXTRA);
        pulse_start(6'd32, 5'd0);
        chk("t7_start_on_done_ignored", busy, 1'b0);
        expect_dump(6'd32, 0);
        s = cyc_n;
        pulse_start(6'd32, 5'd0);
        chk("t7_start_after_done", busy, 1'b1);
        wait_done("t7b", s, 2 + CHK_EXTRA);

        // Reset mid-dump aborts at once; nothing is resent afterwards.
        expect_dump(6'd20, 2);
        pulse_start(6'd20, 5'd2);
        cyc(); cyc(); cyc();
        chk("t8_in_send", tx_valid, 1'b1);
        rst = 1'b0;
        #1;
        chk("t8_async_valid", tx_valid, 1'b0);
        chk("t8_async_busy", busy, 1'b0);
        chk("t8_async_addr", dbg_addr, 6'd0);
        exp_q.delete();
        cyc();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) cyc();
        chk("t8_idle_valid", tx_valid, 1'b0);
        chk("t8_idle_busy", busy, 1'b0);
        expect_dump(6'd8, 1);
        s = cyc_n;
        pulse_start(6'd8, 5'd1);
        wait_done("t8", s, 8 + CHK_EXTRA);

        cyc(); cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
